// File: rtl/vfd_scanout.sv
// 640x480@60 scanout: walks the 8-bpp VRAM, expands RRRGGGBB to 24-bit RGB with aligned sync/blank.
// Optional colour-bar test pattern under VFD_SCANOUT_TESTPAT_EN (selected at run time by test_mode).
module vfd_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce_pix,
   output logic [18:0] vram_addr,
   input  logic [7:0]  vram_data,
   input  logic        test_mode,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        hs,
   output logic        vs,
   output logic        hblank,
   output logic        vblank,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       h_last;
   logic       frame_wrap;
   logic       active0;
   logic       hs0;
   logic       vs0;
   logic       hblank0;
   logic       vblank0;

   logic [7:0] data1;
   logic       active1;
   logic       hs1;
   logic       vs1;
   logic       hblank1;
   logic       vblank1;

   logic [7:0] pix_r;
   logic [7:0] pix_g;
   logic [7:0] pix_b;

`ifdef VFD_SCANOUT_TESTPAT_EN
   logic [2:0] bar1;
`else
   logic       unused_test_mode;
   assign unused_test_mode = test_mode;
`endif

   always_comb begin
      h_last     = (hcnt == H_LAST);
      frame_wrap = h_last && (vcnt == V_LAST);
      active0    = (hcnt < H_ACT) && (vcnt < V_ACT);
      hs0        = !((hcnt >= HS_BEG) && (hcnt < HS_END));
      vs0        = !((vcnt >= VS_BEG) && (vcnt < VS_END));
      hblank0    = (hcnt >= H_ACT);
      vblank0    = (vcnt >= V_ACT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (ce_pix) begin
         hcnt <= h_last ? 10'd0 : hcnt + 10'd1;
         if (h_last) begin
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
         end
      end
   end

   // The address parks on the last pixel after the final active one so it never leaves the frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vram_addr <= '0;
      end else if (ce_pix) begin
         if (frame_wrap) begin
            vram_addr <= '0;
         end else if (active0 && (vram_addr != ADDR_LAST)) begin
            vram_addr <= vram_addr + 19'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= ce_pix && frame_wrap;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data1   <= '0;
         active1 <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
         hblank1 <= 1'b1;
         vblank1 <= 1'b1;
`ifdef VFD_SCANOUT_TESTPAT_EN
         bar1    <= '0;
`endif
      end else if (ce_pix) begin
         data1   <= vram_data;
         active1 <= active0;
         hs1     <= hs0;
         vs1     <= vs0;
         hblank1 <= hblank0;
         vblank1 <= vblank0;
`ifdef VFD_SCANOUT_TESTPAT_EN
         bar1    <= hcnt[9:7];
`endif
      end
   end

   // Bit replication spreads each 3/3/2-bit channel across the full 8-bit range.
   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      if (active1) begin
`ifdef VFD_SCANOUT_TESTPAT_EN
         if (test_mode) begin
            pix_r = {8{bar1[2]}};
            pix_g = {8{bar1[1]}};
            pix_b = {8{bar1[0]}};
         end else begin
            pix_r = {data1[7:5], data1[7:5], data1[7:6]};
            pix_g = {data1[4:2], data1[4:2], data1[4:3]};
            pix_b = {4{data1[1:0]}};
         end
`else
         pix_r = {data1[7:5], data1[7:5], data1[7:6]};
         pix_g = {data1[4:2], data1[4:2], data1[4:3]};
         pix_b = {4{data1[1:0]}};
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r      <= '0;
         g      <= '0;
         b      <= '0;
         hs     <= 1'b1;
         vs     <= 1'b1;
         hblank <= 1'b1;
         vblank <= 1'b1;
      end else if (ce_pix) begin
         r      <= pix_r;
         g      <= pix_g;
         b      <= pix_b;
         hs     <= hs1;
         vs     <= vs1;
         hblank <= hblank1;
         vblank <= vblank1;
      end
   end

endmodule

// File: tb/tb_vfd_scanout.sv
// Bench for vfd_scanout with a shortened vertical frame (9 lines) so whole frames fit in a short run.
// VRAM is modelled as data = addr[7:0], combinationally valid within the clock after the address.
module tb_vfd_scanout;

   localparam int V_ACT = 4;
   localparam int V_FPR = 1;
   localparam int V_SYN = 2;
   localparam int V_BPR = 2;
   localparam int V_TOT = V_ACT + V_FPR + V_SYN + V_BPR;
   localparam int FRAME = 800 * V_TOT;

`ifdef VFD_SCANOUT_TESTPAT_EN
   localparam bit TESTPAT = 1'b1;
   localparam int NT = 9;
   int          tq[NT]   = '{0, 100, 130, 255, 256, 400, 520, 639, 640};
   logic [23:0] trgb[NT] = '{24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF, 24'h00FF00,
                             24'h00FFFF, 24'hFF0000, 24'hFF0000, 24'h000000};
`else
   localparam bit TESTPAT = 1'b0;
   localparam int NT = 4;
   int          tq[NT]   = '{5, 130, 255, 700};
   logic [23:0] trgb[NT] = '{24'h002455, 24'h9200AA, 24'hFFFFFF, 24'h000000};
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce_pix = 1'b0;
   logic        test_mode = 1'b0;
   logic [7:0]  vram_data;
   logic [18:0] vram_addr;
   logic [7:0]  r, g, b;
   logic        hs, vs, hblank, vblank, frame_start;

   int errors = 0;
   int checks = 0;
   int ce_div = 1;

   vfd_scanout #(
      .V_ACTIVE(V_ACT), .V_FP(V_FPR), .V_SYNC(V_SYN), .V_BP(V_BPR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
      .vram_addr(vram_addr), .vram_data(vram_data), .test_mode(test_mode),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   always_comb vram_data = vram_addr[7:0];

   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         ph = (ph + 1 >= ce_div) ? 0 : ph + 1;
         ce_pix = (ph == 0);
      end
   end

   // Expected address at counter position p, derived from the raster invariant.
   function automatic logic [18:0] exp_addr(input int p);
      int h, v;
      h = p % 800;
      v = (p / 800) % V_TOT;
      if (v < V_ACT && h < 640) return 19'(v * 640 + h);
      if (v < V_ACT - 1) return 19'((v + 1) * 640);
      return 19'(V_ACT * 640 - 1);
   endfunction

   // Expected {hs,vs,hblank,vblank,r,g,b} for the pixel at counter position q.
   function automatic logic [27:0] exp_out(input int q, input logic tm);
      int h, v;
      logic [18:0] a;
      logic [7:0]  d;
      logic [9:0]  hv;
      logic [23:0] rgb;
      if (q < 0) return {4'b1111, 24'h0};
      h = q % 800;
      v = (q / 800) % V_TOT;
      rgb = '0;
      if (h < 640 && v < V_ACT) begin
         a = exp_addr(q);
         d = a[7:0];
         rgb = {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
         if (tm && TESTPAT) begin
            hv = 10'(h);
            rgb = {{8{hv[9]}}, {8{hv[8]}}, {8{hv[7]}}};
         end
      end
      return {(h >= 656 && h < 752) ? 1'b0 : 1'b1, (v >= 5 && v < 7) ? 1'b0 : 1'b1,
              (h >= 640), (v >= V_ACT), rgb};
   endfunction

   task automatic wait_ce();
      do @(posedge clk); while (ce_pix !== 1'b1);
      #1;
   endtask

   task automatic applyStimulus_reset_release();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (vram_addr !== 19'd0) begin
         errors++; $display("[TB] FAIL reset_addr got=%0d exp=0", vram_addr);
      end
      checks++;
      if ({r, g, b} !== 24'h0) begin
         errors++; $display("[TB] FAIL reset_rgb got=%h exp=000000", {r, g, b});
      end
      checks++;
      if ({hs, vs, hblank, vblank} !== 4'b1111) begin
         errors++; $display("[TB] FAIL reset_sync got=%b exp=1111", {hs, vs, hblank, vblank});
      end
      checks++;
      if (frame_start !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_fs got=%b exp=0", frame_start);
      end
   endtask

   task automatic test_frame_timing(input int div);
      int hs_low, hb_high, vs_low, vb_high, fs_count, fs_at, max_addr;
      logic [18:0] ea;
      logic [27:0] e;
      ce_div = div;
      test_mode = 1'b0;
      applyStimulus_reset_release();
      hs_low = 0; hb_high = 0; vs_low = 0; vb_high = 0;
      fs_count = 0; fs_at = -1; max_addr = 0;
      for (int n = 1; n <= FRAME + 2; n++) begin
         wait_ce();
         ea = exp_addr(n % FRAME);
         e  = exp_out(n - 2, 1'b0);
         checks++;
         if (vram_addr !== ea) begin
            errors++; $display("[TB] FAIL addr div=%0d n=%0d got=%0d exp=%0d", div, n, vram_addr, ea);
         end
         checks++;
         if ({hs, vs, hblank, vblank, r, g, b} !== e) begin
            errors++;
            $display("[TB] FAIL video div=%0d n=%0d got=%h exp=%h", div, n,
                     {hs, vs, hblank, vblank, r, g, b}, e);
         end
         checks++;
         if (frame_start !== (n == FRAME)) begin
            errors++; $display("[TB] FAIL frame_start div=%0d n=%0d got=%b", div, n, frame_start);
         end
         if (frame_start === 1'b1) begin
            fs_count++; fs_at = n;
         end
         if (int'(vram_addr) > max_addr) max_addr = int'(vram_addr);
         if (n >= 2 && n <= FRAME + 1) begin
            if (hs === 1'b0) hs_low++;
            if (hblank === 1'b1) hb_high++;
            if (vs === 1'b0) vs_low++;
            if (vblank === 1'b1) vb_high++;
         end
         if (n == 1605) begin
            checks++;
            if (vram_addr !== 19'd1285) begin
               errors++; $display("[TB] FAIL addr_h5_v2 got=%0d exp=1285", vram_addr);
            end
         end
         if (n == 1607) begin
            checks++;
            if ({r, g, b} !== 24'h002455) begin
               errors++; $display("[TB] FAIL rgb_h5_v2 got=%h exp=002455", {r, g, b});
            end
         end
         for (int k = 1; k < div; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (vram_addr !== ea) begin
               errors++; $display("[TB] FAIL hold_addr n=%0d got=%0d exp=%0d", n, vram_addr, ea);
            end
            checks++;
            if ({hs, vs, hblank, vblank, r, g, b} !== e) begin
               errors++;
               $display("[TB] FAIL hold_video n=%0d got=%h exp=%h", n,
                        {hs, vs, hblank, vblank, r, g, b}, e);
            end
            checks++;
            if (frame_start !== 1'b0) begin
               errors++; $display("[TB] FAIL hold_fs n=%0d got=%b exp=0", n, frame_start);
            end
         end
      end
      checks++;
      if (hs_low !== 96 * V_TOT) begin
         errors++; $display("[TB] FAIL hs_low_count got=%0d exp=%0d", hs_low, 96 * V_TOT);
      end
      checks++;
      if (hb_high !== 160 * V_TOT) begin
         errors++; $display("[TB] FAIL hblank_count got=%0d exp=%0d", hb_high, 160 * V_TOT);
      end
      checks++;
      if (vs_low !== 2 * 800) begin
         errors++; $display("[TB] FAIL vs_low_count got=%0d exp=1600", vs_low);
      end
      checks++;
      if (vb_high !== (V_TOT - V_ACT) * 800) begin
         errors++; $display("[TB] FAIL vblank_count got=%0d exp=%0d", vb_high, (V_TOT - V_ACT) * 800);
      end
      checks++;
      if (fs_count !== 1 || fs_at !== FRAME) begin
         errors++; $display("[TB] FAIL fs_pulse got=%0d@%0d exp=1@%0d", fs_count, fs_at, FRAME);
      end
      checks++;
      if (max_addr !== V_ACT * 640 - 1) begin
         errors++; $display("[TB] FAIL max_addr got=%0d exp=%0d", max_addr, V_ACT * 640 - 1);
      end
   endtask

   task automatic test_reset_midframe();
      int first_hs;
      ce_div = 1;
      test_mode = 1'b0;
      applyStimulus_reset_release();
      for (int n = 1; n <= 1900; n++) wait_ce();
      checks++;
      if (vram_addr !== 19'd1580) begin
         errors++; $display("[TB] FAIL mid_addr got=%0d exp=1580", vram_addr);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (vram_addr !== 19'd0 || frame_start !== 1'b0) begin
         errors++; $display("[TB] FAIL async_addr got=%0d/%b exp=0/0", vram_addr, frame_start);
      end
      checks++;
      if ({hs, vs, hblank, vblank, r, g, b} !== {4'b1111, 24'h0}) begin
         errors++;
         $display("[TB] FAIL async_video got=%h exp=f000000", {hs, vs, hblank, vblank, r, g, b});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      first_hs = -1;
      for (int n = 1; n <= 700; n++) begin
         wait_ce();
         if (hs === 1'b0 && first_hs < 0) first_hs = n;
         if (n == 700) begin
            checks++;
            if (vram_addr !== 19'd640) begin
               errors++; $display("[TB] FAIL restart_addr got=%0d exp=640", vram_addr);
            end
         end
      end
      // Counter reaches 656 on ce 656; the registered output follows two ce later.
      checks++;
      if (first_hs !== 658) begin
         errors++; $display("[TB] FAIL first_hs got=%0d exp=658", first_hs);
      end
   endtask

   task automatic test_test_mode();
      ce_div = 1;
      test_mode = 1'b1;
      applyStimulus_reset_release();
      for (int n = 1; n <= 702; n++) begin
         wait_ce();
         if (n == 300) begin
            checks++;
            if (vram_addr !== 19'd300) begin
               errors++; $display("[TB] FAIL tm_addr got=%0d exp=300", vram_addr);
            end
         end
         for (int i = 0; i < NT; i++) begin
            if (n == tq[i] + 2) begin
               checks++;
               if ({r, g, b} !== trgb[i]) begin
                  errors++; $display("[TB] FAIL tm_rgb h=%0d got=%h exp=%h", tq[i], {r, g, b}, trgb[i]);
               end
            end
         end
      end
      test_mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_timing(1);
      test_frame_timing(3);
      test_reset_midframe();
      test_test_mode();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
